// File: rtl/rgb_scene_sequencer.sv
// Key-driven scene controller for the two RGB LED channels; steps colour phase on a ms dwell.
// All outputs registered (one cycle after inputs); no backpressure, key_pulse always wins over a step.
module rgb_scene_sequencer #(
    parameter int TICK_DIV = 12000,
    parameter int STEP_MS  = 500
) (
    input  logic       clk,
    input  logic       real_rst,
    input  logic       key_pulse,
    input  logic [3:0] speed,
    output logic [1:0] scene,
    output logic [2:0] color0,
    output logic [2:0] color1,
    output logic       en0,
    output logic       en1,
    output logic [3:0] freq0,
    output logic [3:0] freq1,
    output logic       step_strobe
);

    localparam logic [1:0]  S_OFF     = 2'd0;
    localparam logic [1:0]  S_BREATH  = 2'd1;
    localparam logic [1:0]  S_CHASE   = 2'd2;
    localparam logic [1:0]  S_ALT     = 2'd3;
    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [13:0] STEP_W    = 14'(STEP_MS);
    localparam logic [2:0]  CODE_OFF  = 3'b111;

    logic [1:0]  phase;
    logic        side;
    logic [15:0] presc;
    logic [13:0] ms_cnt;

    logic        run;
    logic        tick;
    logic        step;
    logic [13:0] dwell;
    logic [13:0] dwell_m1;
    logic [1:0]  scene_nx;
    logic [1:0]  phase_nx;
    logic [1:0]  phase_adv;
    logic        side_nx;
    logic [2:0]  color0_nx;
    logic [2:0]  color1_nx;
    logic        en0_nx;
    logic        en1_nx;
    logic [3:0]  freq1_nx;

    function automatic logic [1:0] next_phase(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [2:0] code(input logic [1:0] p);
        case (p)
            2'd0:    return 3'b110;
            2'd1:    return 3'b101;
            default: return 3'b011;
        endcase
    endfunction

    // Greater-or-equal compare lets a mid-dwell speed decrease step at the next tick.
    assign run       = (scene != S_OFF);
    assign tick      = run && (presc == TICK_LAST);
    assign dwell     = STEP_W * (14'(speed) + 14'd1);
    assign dwell_m1  = dwell - 14'd1;
    assign step      = tick && !key_pulse && (ms_cnt >= dwell_m1);
    assign phase_adv = next_phase(phase);

    always_comb begin
        scene_nx = scene;
        phase_nx = phase;
        side_nx  = side;
        if (key_pulse) begin
            scene_nx = scene + 2'd1;
            phase_nx = 2'd0;
            side_nx  = 1'b0;
        end else if (step) begin
            if (scene == S_ALT) begin
                side_nx = ~side;
                if (side) phase_nx = phase_adv;
            end else begin
                phase_nx = phase_adv;
            end
        end
    end

    always_comb begin
        color0_nx = CODE_OFF;
        color1_nx = CODE_OFF;
        en0_nx    = 1'b0;
        en1_nx    = 1'b0;
        freq1_nx  = speed;
        case (scene_nx)
            S_BREATH: begin
                en0_nx    = 1'b1;
                en1_nx    = 1'b1;
                color0_nx = code(phase_nx);
                color1_nx = code(phase_nx);
            end
            S_CHASE: begin
                en0_nx    = 1'b1;
                en1_nx    = 1'b1;
                color0_nx = code(phase_nx);
                color1_nx = code(next_phase(phase_nx));
                freq1_nx  = ~speed;
            end
            S_ALT: begin
                if (side_nx) begin
                    en1_nx    = 1'b1;
                    color1_nx = code(phase_nx);
                end else begin
                    en0_nx    = 1'b1;
                    color0_nx = code(phase_nx);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge real_rst) begin
        if (!real_rst) begin
            scene       <= S_OFF;
            phase       <= 2'd0;
            side        <= 1'b0;
            presc       <= 16'd0;
            ms_cnt      <= 14'd0;
            color0      <= CODE_OFF;
            color1      <= CODE_OFF;
            en0         <= 1'b0;
            en1         <= 1'b0;
            freq0       <= 4'd0;
            freq1       <= 4'd0;
            step_strobe <= 1'b0;
        end else begin
            scene <= scene_nx;
            phase <= phase_nx;
            side  <= side_nx;
            if (key_pulse || !run || tick) presc <= 16'd0;
            else                           presc <= presc + 16'd1;
            if (key_pulse || !run || step) ms_cnt <= 14'd0;
            else if (tick)                 ms_cnt <= ms_cnt + 14'd1;
            color0      <= color0_nx;
            color1      <= color1_nx;
            en0         <= en0_nx;
            en1         <= en1_nx;
            freq0       <= speed;
            freq1       <= freq1_nx;
            step_strobe <= step;
        end
    end

endmodule

// File: tb/tb_rgb_scene_sequencer.sv
// Directed vector bench for rgb_scene_sequencer with TICK_DIV=4, STEP_MS=2 (8 clk per step at speed 0).
module tb_rgb_scene_sequencer;

    logic       clk = 1'b0;
    logic       real_rst;
    logic       key_pulse;
    logic [3:0] speed;
    logic [1:0] scene;
    logic [2:0] color0, color1;
    logic       en0, en1;
    logic [3:0] freq0, freq1;
    logic       step_strobe;

    int n_pass  = 0;
    int n_total = 0;

    rgb_scene_sequencer #(.TICK_DIV(4), .STEP_MS(2)) dut (
        .clk        (clk),
        .real_rst   (real_rst),
        .key_pulse  (key_pulse),
        .speed      (speed),
        .scene      (scene),
        .color0     (color0),
        .color1     (color1),
        .en0        (en0),
        .en1        (en1),
        .freq0      (freq0),
        .freq1      (freq1),
        .step_strobe(step_strobe)
    );

    always #5 clk = ~clk;

    // Output vector: {scene, color0, color1, en0, en1, freq0, freq1, step_strobe}
    logic [18:0] out_vec;
    assign out_vec = {scene, color0, color1, en0, en1, freq0, freq1, step_strobe};

    typedef struct {
        logic        key;
        logic [3:0]  spd;
        int          cyc;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [18:0] ev(input logic [1:0] sc, input logic [2:0] c0, input logic [2:0] c1,
                                       input logic e0, input logic e1, input logic [3:0] f0,
                                       input logic [3:0] f1, input logic stb);
        return {sc, c0, c1, e0, e1, f0, f1, stb};
    endfunction

    task automatic add(input logic key, input logic [3:0] spd, input int cyc, input logic [18:0] exp);
        vec_t v;
        v.key = key;
        v.spd = spd;
        v.cyc = cyc;
        v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [18:0] RST_VEC = {2'd0, 3'b111, 3'b111, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0};

    initial begin
        int strobes;
        real_rst  = 1'b1;
        key_pulse = 1'b0;
        speed     = 4'd0;
        #1 real_rst = 1'b0;
        #2;
        check("reset_values", 32'(out_vec), 32'(RST_VEC));
        repeat (3) tick();
        real_rst = 1'b1;

        strobes = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (step_strobe) strobes++;
        end
        check("off_no_strobe", strobes, 0);
        check("off_idle_outputs", 32'(out_vec), 32'(RST_VEC));

        // BREATH, speed 0: steps every 8 clk
        add(1, 0, 1, ev(1, 3'b110, 3'b110, 1, 1, 0, 0, 0));
        add(0, 0, 8, ev(1, 3'b101, 3'b101, 1, 1, 0, 0, 1));
        add(0, 0, 1, ev(1, 3'b101, 3'b101, 1, 1, 0, 0, 0));
        add(0, 0, 7, ev(1, 3'b011, 3'b011, 1, 1, 0, 0, 1));
        add(0, 0, 8, ev(1, 3'b110, 3'b110, 1, 1, 0, 0, 1));
        add(0, 0, 7, ev(1, 3'b110, 3'b110, 1, 1, 0, 0, 0));
        // key coincides with a step: CHASE at phase 0, no strobe
        add(1, 0, 1, ev(2, 3'b110, 3'b101, 1, 1, 0, 4'hf, 0));
        // CHASE, speed 3: 32 clk per step
        add(0, 3, 31, ev(2, 3'b110, 3'b101, 1, 1, 3, 4'hc, 0));
        add(0, 3, 1, ev(2, 3'b101, 3'b011, 1, 1, 3, 4'hc, 1));
        add(0, 3, 32, ev(2, 3'b011, 3'b110, 1, 1, 3, 4'hc, 1));
        add(0, 3, 31, ev(2, 3'b011, 3'b110, 1, 1, 3, 4'hc, 0));
        // key coincides with a step again: ALT side 0 phase 0
        add(1, 3, 1, ev(3, 3'b110, 3'b111, 1, 0, 3, 3, 0));
        // ALT, speed 0: first step 8 clk after the key
        add(0, 0, 7, ev(3, 3'b110, 3'b111, 1, 0, 0, 0, 0));
        add(0, 0, 1, ev(3, 3'b111, 3'b110, 0, 1, 0, 0, 1));
        add(0, 0, 8, ev(3, 3'b101, 3'b111, 1, 0, 0, 0, 1));
        add(0, 0, 8, ev(3, 3'b111, 3'b101, 0, 1, 0, 0, 1));
        add(0, 0, 8, ev(3, 3'b011, 3'b111, 1, 0, 0, 0, 1));
        add(1, 0, 1, ev(0, 3'b111, 3'b111, 0, 0, 0, 0, 0));
        // scene wrap with speed 5
        add(1, 5, 1, ev(1, 3'b110, 3'b110, 1, 1, 5, 5, 0));
        add(1, 5, 1, ev(2, 3'b110, 3'b101, 1, 1, 5, 4'ha, 0));
        add(1, 5, 1, ev(3, 3'b110, 3'b111, 1, 0, 5, 5, 0));
        add(1, 5, 1, ev(0, 3'b111, 3'b111, 0, 0, 5, 5, 0));
        add(0, 5, 50, ev(0, 3'b111, 3'b111, 0, 0, 5, 5, 0));

        foreach (tbl[i]) begin
            key_pulse = tbl[i].key;
            speed     = tbl[i].spd;
            tick();
            key_pulse = 1'b0;
            repeat (tbl[i].cyc - 1) tick();
            check($sformatf("vec%0d", i), 32'(out_vec), 32'(tbl[i].exp));
        end

        // speed 15 -> 0 mid-dwell: step at the next tick instead of 128 clk later
        key_pulse = 1'b1;
        speed     = 4'd15;
        tick();
        key_pulse = 1'b0;
        repeat (20) tick();
        check("slow_dwell_no_step", 32'({step_strobe, color0}), 32'({1'b0, 3'b110}));
        speed = 4'd0;
        repeat (3) tick();
        check("speed_drop_pre_tick", 32'(step_strobe), 32'd0);
        tick();
        check("speed_drop_step", 32'({step_strobe, color0, color1}), 32'({1'b1, 3'b101, 3'b101}));
        speed = 4'd7;
        repeat (2) tick();
        check("pre_reset_active", 32'(out_vec), 32'(ev(1, 3'b101, 3'b101, 1, 1, 7, 7, 0)));

        // asynchronous reset between clock edges
        #2 real_rst = 1'b0;
        #1;
        check("async_reset", 32'(out_vec), 32'(RST_VEC));
        tick();
        real_rst = 1'b1;

        key_pulse = 1'b1;
        speed     = 4'd0;
        tick();
        key_pulse = 1'b0;
        repeat (7) tick();
        check("post_reset_no_early_step", 32'(step_strobe), 32'd0);
        tick();
        check("post_reset_first_step", 32'({step_strobe, color0}), 32'({1'b1, 3'b101}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rgb_scene_sequencer.md
Name: rgb_scene_sequencer

Overview:
- Scene controller for the board's two RGB LED channels (LED0 = N5/R3/R4 group, LED1 = T5/T6/T4 group).
- Takes a one-cycle debounced key pulse and a 4-bit speed setting.
- Selects one of four lighting scenes and steps the colour phase on a millisecond-timed dwell.
- Drives registered per-channel colour-control codes, enables and breath-frequency settings into the breath PWM datapath.

Parameters:
- TICK_DIV, 12000, clk cycles per 1 ms tick (12 MHz board clock); legal range 2..65535.
- STEP_MS, 500, base dwell per colour step in ms; legal range 1..1023.

Ports:
- clk  in  1  system clock.
- real_rst  in  1  asynchronous reset, active-low (0 = reset).
- key_pulse  in  1  debounced key event, one clk cycle high per press.
- speed  in  4  dwell multiplier and breath frequency select.
- scene  out  2  current scene: 0 OFF, 1 BREATH, 2 CHASE, 3 ALT.
- color0  out  3  LED0 colour code, active-low; bit0 R, bit1 G, bit2 B.
- color1  out  3  LED1 colour code, same encoding.
- en0  out  1  LED0 enable; 0 forces the channel dark downstream.
- en1  out  1  LED1 enable.
- freq0  out  4  breath frequency select for LED0.
- freq1  out  4  breath frequency select for LED1.
- step_strobe  out  1  one-cycle pulse on every colour step.

Behaviour:
- Reset (real_rst=0, asynchronous) clears all state and outputs:
  - scene=0, phase=0, side=0, prescaler=0, ms counter=0.
  - color0=color1=3'b111, en0=en1=0, freq0=freq1=0, step_strobe=0.
- All outputs are registered and reflect internal state one cycle later.
- Scene FSM advances on key_pulse: OFF -> BREATH -> CHASE -> ALT -> OFF (2-bit wrap).
- On a key_pulse cycle:
  - prescaler, ms counter, phase and side clear to 0.
  - No step is taken in that cycle; key_pulse beats a coincident step.
- Timebase:
  - 16-bit prescaler counts 0..TICK_DIV-1; tick is asserted on the terminal count.
  - 14-bit ms counter increments on each tick.
  - dwell = STEP_MS*(speed+1), computed as a 14-bit product; maximum 1023*16 = 16368.
  - A step fires when tick=1 and ms_count >= dwell-1; the ms counter then clears.
  - The >= compare means lowering speed mid-dwell causes a step at the next tick, never a lost wrap.
- Timebase runs only in scenes 1..3. In OFF, prescaler and ms counter hold at 0 and step_strobe stays 0.
- Colour phase is a 0..2 counter; phase 2 wraps to 0.
  - Code table: phase 0 -> 3'b110 (R), 1 -> 3'b101 (G), 2 -> 3'b011 (B).
  - Code 3'b111 means off.
- Scene outputs:
  - OFF: en0=en1=0, color0=color1=111, freq0=freq1=speed.
  - BREATH:
    - en0=en1=1, color0=color1=code(phase), freq0=freq1=speed.
    - Each step advances phase.
  - CHASE:
    - en0=en1=1, color0=code(phase), color1=code((phase+1) mod 3).
    - freq0=speed; freq1=~speed (LED1 counter-rate).
    - Each step advances phase.
  - ALT:
    - side=0: LED0 is active with colour code(phase), en0=1; LED1 is en1=0 with colour 111.
    - side=1: mirrored, LED1 active.
    - Each step toggles side; phase advances only on the side 1->0 step.
    - freq0=freq1=speed.
- step_strobe: registered; high for exactly the one cycle after each step fires.
- speed is sampled every cycle, with no synchroniser required (static switches). freq outputs follow speed with 1-cycle latency.
- real_rst asserted mid-dwell or mid-scene returns immediately to the reset state. The first step after release comes a full dwell later.

Test Plan:
Bench parameters: TICK_DIV=4, STEP_MS=2.
- Reset then release, no key -> scene=0, en0=en1=0, colors 111, step_strobe never high over 200 cycles.
- One key_pulse, speed=0 -> scene=1 next cycle; step_strobe period exactly 8 clk; colors cycle 110 -> 101 -> 011 -> 110 on both channels.
- speed=3, scene=2 -> step period 32 clk; at phase 2 color0=011, color1=110; freq1=4'b1100.
- Scene=3, speed=0 -> en alternates 10/01 every 8 clk; color0 advances only after en returns to 10; inactive channel shows 111.
- key_pulse in the same cycle as a step -> scene increments, no step_strobe, phase=0; next step is 8 clk after the key.
- Set speed 15 -> 0 at ms_count=5 during dwell, then assert real_rst=0 mid-dwell:
  - After the speed change, a step fires at the next tick.
  - On real_rst=0, all outputs return to reset values asynchronously, with no clk edge needed.
- Four key_pulses -> scene wraps 1, 2, 3, 0; outputs off in scene 0.
